sram_burst_ctrl: RTL and testbench

Parametrised asynchronous-SRAM controller for the flight-data memory path. It is the next-generation replacement for the fixed 16-bit, single-access SRAM port. It accepts burst read/write commands from the memory controller over a valid/ready handshake, and generates SRAM address, lane-strobe, CE/WE/OE timing with a configurable number of wait states. It sits between the memory controller and the board SRAM pins, and supports multiple data lanes sharing one address bus.

---
 rtl/sram_burst_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl.sv
// Burst controller for an asynchronous SRAM: SETUP / ACCESS / HOLD timing per beat with lane strobes.
// Optional write read-back verify is built when SRAM_BURST_CTRL_VERIFY_EN is defined.
module sram_burst_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int LANES       = 2,
    parameter int WAIT_STATES = 1,
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_W-1:0]       i_cmd_addr,
    input  logic [LANE_W-1:0]       i_cmd_lane,
    input  logic [3:0]              i_cmd_len,
    input  logic [DATA_W-1:0]       i_wr_data,
    output logic                    o_wr_ack,
    output logic [DATA_W-1:0]       o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_busy,
    output logic                    o_err,
    output logic [ADDR_W-1:0]       o_sram_a,
    inout  wire  [DATA_W*LANES-1:0] io_sram_dq,
    output logic [LANES-1:0]        o_sram_bs_n,
    output logic                    o_sram_ce_n,
    output logic                    o_sram_we_n,
    output logic                    o_sram_oe_n
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

`ifdef SRAM_BURST_CTRL_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_VSETUP, S_VACCESS, S_VHOLD
    } state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} state_t;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LANE_W-1:0]   r_lane;
    logic [3:0]          r_beats;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_wait;
    logic [DATA_W-1:0]   r_rd_data;
    logic                w_access_last;
    logic                w_last_beat;
    logic                w_beat_end;
    logic                w_active;
    logic                w_dq_oe;
    logic [DATA_W-1:0]   w_rd_lane;

    assign w_access_last = (r_wait == 4'd0);
    assign w_last_beat   = (r_beats == 4'd0);

`ifdef SRAM_BURST_CTRL_VERIFY_EN
    // A write beat only finishes once its read-back has completed.
    assign w_beat_end = (r_state == S_HOLD && !r_write) || (r_state == S_VHOLD);
`else
    assign w_beat_end = (r_state == S_HOLD);
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_cmd_valid) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_access_last) w_next = S_HOLD;
            S_HOLD: begin
                w_next = w_last_beat ? S_IDLE : S_SETUP;
`ifdef SRAM_BURST_CTRL_VERIFY_EN
                if (r_write) w_next = S_VSETUP;
`endif
            end
`ifdef SRAM_BURST_CTRL_VERIFY_EN
            S_VSETUP:  w_next = S_VACCESS;
            S_VACCESS: if (w_access_last) w_next = S_VHOLD;
            S_VHOLD:   w_next = w_last_beat ? S_IDLE : S_SETUP;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_active    = (r_state != S_IDLE);
        o_cmd_ready = !w_active;
        o_busy      = w_active;
        o_sram_ce_n = !w_active;
        o_sram_bs_n = '1;
        for (int k = 0; k < LANES; k++) begin
            if (w_active && r_lane == LANE_W'(k)) o_sram_bs_n[k] = 1'b0;
        end
        o_sram_we_n = !(r_state == S_ACCESS && r_write);
`ifdef SRAM_BURST_CTRL_VERIFY_EN
        o_sram_oe_n = !((r_state == S_ACCESS && !r_write) || r_state == S_VACCESS);
`else
        o_sram_oe_n = !(r_state == S_ACCESS && !r_write);
`endif
        o_wr_ack    = (r_state == S_SETUP) && r_write;
        o_rd_valid  = (r_state == S_HOLD) && !r_write;
        // Drive only in write ACCESS/HOLD, where OE_N is guaranteed high.
        w_dq_oe     = r_write && (r_state == S_ACCESS || r_state == S_HOLD);
    end

    always_comb begin
        w_rd_lane = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_lane == LANE_W'(k)) w_rd_lane = io_sram_dq[k*DATA_W +: DATA_W];
        end
    end

    assign io_sram_dq = w_dq_oe ? {LANES{r_wdata}} : 'z;
    assign o_sram_a   = r_addr;
    assign o_rd_data  = r_rd_data;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_addr    <= '0;
            r_lane    <= '0;
            r_beats   <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_wait    <= '0;
            r_rd_data <= '0;
        end else begin
            if (r_state == S_IDLE && i_cmd_valid) begin
                r_addr  <= i_cmd_addr;
                r_lane  <= i_cmd_lane;
                r_beats <= i_cmd_len;
                r_write <= i_cmd_write;
            end
            if (r_state == S_SETUP && r_write) r_wdata <= i_wr_data;
`ifdef SRAM_BURST_CTRL_VERIFY_EN
            if (r_state == S_SETUP || r_state == S_VSETUP) r_wait <= WS;
`else
            if (r_state == S_SETUP) r_wait <= WS;
`endif
            else if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
            if (r_state == S_ACCESS && !r_write && w_access_last) r_rd_data <= w_rd_lane;
            if (w_beat_end && !w_last_beat) begin
                r_addr  <= r_addr + 1'b1;
                r_beats <= r_beats - 4'd1;
            end
        end
    end

`ifdef SRAM_BURST_CTRL_VERIFY_EN
    logic r_err;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)                                                   r_err <= 1'b0;
        else if (r_state == S_IDLE && i_cmd_valid)                      r_err <= 1'b0;
        else if (r_state == S_VACCESS && w_access_last && w_rd_lane != r_wdata) r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: SRAM behavioural model, read-data scoreboard, scenario tasks.
`timescale 1ns/1ps
module tb_sram_burst_ctrl;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int LANES  = 2;
    localparam int WS     = 1;
    localparam int BEAT   = WS + 3;
`ifdef SRAM_BURST_CTRL_VERIFY_EN
    localparam int WR_BEAT = 2 * BEAT;
`else
    localparam int WR_BEAT = BEAT;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [17:0] cmd_addr = '0;
    logic        cmd_lane = 1'b0;
    logic [3:0]  cmd_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err;
    logic [17:0] sram_a;
    wire  [31:0] sram_dq;
    logic [1:0]  bs_n;
    logic        ce_n, we_n, oe_n;

    int n_checks = 0;
    int n_errors = 0;

    sram_burst_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .WAIT_STATES(WS)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_lane(cmd_lane), .i_cmd_len(cmd_len),
        .i_wr_data(wr_data), .o_wr_ack(wr_ack), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_busy(busy), .o_err(err), .o_sram_a(sram_a), .io_sram_dq(sram_dq),
        .o_sram_bs_n(bs_n), .o_sram_ce_n(ce_n), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: byte-lane-strobed writes while WE_N low, drives the addressed word while OE_N low.
    logic [31:0] mem [logic [17:0]];
    logic        stuck_bit0 = 1'b0;
    logic [31:0] model_rd = '0;
    logic        model_oe;

    function automatic logic [31:0] mem_rd(input logic [17:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [15:0] lane_of(input logic [31:0] w, input logic l);
        return l ? w[31:16] : w[15:0];
    endfunction

    always @(negedge clk) begin
        logic [31:0] w;
        logic [15:0] ld;
        if (!ce_n && !we_n) begin
            w = mem_rd(sram_a);
            for (int k = 0; k < 2; k++) begin
                if (!bs_n[k]) begin
                    ld = sram_dq[k*16 +: 16];
                    if (stuck_bit0) ld[0] = 1'b0;
                    w[k*16 +: 16] = ld;
                end
            end
            mem[sram_a] = w;
        end
        model_rd = mem_rd(sram_a);
    end

    assign model_oe = !ce_n && !oe_n && we_n;
    assign sram_dq  = model_oe ? model_rd : 'z;

    // Scoreboard for read data plus a bus-contention watch.
    logic [15:0] exp_q [$];

    always @(negedge clk) begin
        logic [15:0] e;
        if (rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_unexpected: RD_VALID with data %h, none expected", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_errors++;
                    $display("FAIL rd_data: got %h want %h", rd_data, e);
                end
            end
        end
        if (!oe_n) begin
            n_checks++;
            if (dut.w_dq_oe !== 1'b0) begin
                n_errors++;
                $display("FAIL contention: DQ driven while OE_N=0 at addr %h", sram_a);
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [17:0] a, input logic l,
                            input logic [3:0] len, input logic [15:0] d);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_lane = l; cmd_len = len; wr_data = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!cmd_ready) begin
            n_errors++;
            $display("FAIL cmd_ready_timeout: CMD_READY=%b want 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy_n, output int acks, output int rds);
        busy_n = 0; acks = 0; rds = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_n++;
            if (wr_ack) acks++;
            if (rd_valid) rds++;
        end
        n_checks++;
        if (busy) begin
            n_errors++;
            $display("FAIL idle_timeout: BUSY=%b want 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, wr_ack, rd_valid, err, ce_n, we_n, oe_n} !== 8'b1000_0111) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 10000111",
                     {cmd_ready, busy, wr_ack, rd_valid, err, ce_n, we_n, oe_n});
        end
        n_checks++;
        if ({sram_a, bs_n, rd_data} !== {18'h0, 2'b11, 16'h0} || dut.w_dq_oe !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_data: A=%h BS_N=%b RD=%h dq_oe=%b want 0/11/0/0",
                     sram_a, bs_n, rd_data, dut.w_dq_oe);
        end
    endtask

    task automatic test_single_write();
        int nb = 0, na = 0, nw = 0, bs_bad = 0, dq_bad = 0;
        send_cmd(1'b1, 18'h00123, 1'b1, 4'd0, 16'hA5C3);
        for (int c = 0; c < WR_BEAT + 3; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (wr_ack) na++;
            if (!we_n) begin
                nw++;
                if (sram_dq !== 32'hA5C3A5C3) dq_bad++;
            end
            if (!ce_n && bs_n !== 2'b01) bs_bad++;
        end
        n_checks++;
        if (na !== 1) begin n_errors++; $display("FAIL wr_ack_count: got %0d want 1", na); end
        n_checks++;
        if (nw !== 2) begin n_errors++; $display("FAIL we_low_cycles: got %0d want 2", nw); end
        n_checks++;
        if (nb !== WR_BEAT) begin n_errors++; $display("FAIL wr_busy_cycles: got %0d want %0d", nb, WR_BEAT); end
        n_checks++;
        if (bs_bad !== 0 || dq_bad !== 0) begin
            n_errors++;
            $display("FAIL wr_lanes: bad BS_N cycles %0d, bad DQ cycles %0d, want 0/0", bs_bad, dq_bad);
        end
        n_checks++;
        if (dut.w_dq_oe !== 1'b0 || lane_of(mem_rd(18'h00123), 1'b1) !== 16'hA5C3) begin
            n_errors++;
            $display("FAIL wr_result: dq_oe=%b mem=%h want 0/a5c3", dut.w_dq_oe, lane_of(mem_rd(18'h00123), 1'b1));
        end
    endtask

    task automatic test_read_burst();
        int t[8];
        logic [17:0] ad[8];
        int n = 0;
        mem[18'h3FFFE] = 32'h0000_1111;
        mem[18'h3FFFF] = 32'h0000_2222;
        mem[18'h00000] = 32'h0000_3333;
        mem[18'h00001] = 32'h0000_4444;
        exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
        exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
        send_cmd(1'b0, 18'h3FFFE, 1'b0, 4'd3, 16'h0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rd_valid && n < 8) begin
                t[n] = c; ad[n] = sram_a; n++;
            end
        end
        n_checks++;
        if (n !== 4) begin n_errors++; $display("FAIL rd_pulses: got %0d want 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            n_checks++;
            if (t[i] !== BEAT * (i + 1) || ad[i] !== 18'(18'h3FFFE + 18'(i))) begin
                n_errors++;
                $display("FAIL rd_beat%0d: cycle %0d addr %h want cycle %0d addr %h",
                         i, t[i], ad[i], BEAT * (i + 1), 18'(18'h3FFFE + 18'(i)));
            end
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_errors++; $display("FAIL rd_missing: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int first_ready = -1, overlap = 0, addr_bad = 0, nb, na, nr;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'h00200; cmd_lane = 1'b0;
        cmd_len = 4'd1; wr_data = 16'hBEEF;
        @(posedge clk);
        #1 cmd_addr = 18'h00300; cmd_len = 4'd0;
        for (int c = 1; c <= 2 * WR_BEAT + 4; c++) begin
            @(negedge clk);
            if (cmd_ready && busy) overlap++;
            if (!ce_n && sram_a != 18'h00200 && sram_a != 18'h00201) addr_bad++;
            if (cmd_ready) begin
                first_ready = c;
                break;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0; wr_data = 16'h7777;
        wait_idle(nb, na, nr);
        n_checks++;
        if (first_ready !== 2 * WR_BEAT + 1) begin
            n_errors++;
            $display("FAIL b2b_ready_cycle: got %0d want %0d", first_ready, 2 * WR_BEAT + 1);
        end
        n_checks++;
        if (overlap !== 0 || addr_bad !== 0) begin
            n_errors++;
            $display("FAIL b2b_overlap: overlap %0d stray-addr %0d want 0/0", overlap, addr_bad);
        end
        n_checks++;
        if (nb !== WR_BEAT || na !== 1) begin
            n_errors++;
            $display("FAIL b2b_second: busy %0d acks %0d want %0d/1", nb, na, WR_BEAT);
        end
        n_checks++;
        if (lane_of(mem_rd(18'h00200), 1'b0) !== 16'hBEEF || lane_of(mem_rd(18'h00201), 1'b0) !== 16'hBEEF ||
            lane_of(mem_rd(18'h00300), 1'b0) !== 16'h7777) begin
            n_errors++;
            $display("FAIL b2b_mem: %h %h %h want beef beef 7777", lane_of(mem_rd(18'h00200), 1'b0),
                     lane_of(mem_rd(18'h00201), 1'b0), lane_of(mem_rd(18'h00300), 1'b0));
        end
    endtask

    task automatic test_reset_mid_burst();
        int nr = 0;
        for (int i = 0; i < 4; i++) mem[18'(18'h00010 + 18'(i))] = {16'hAAA0 + 16'(i), 16'h0};
        exp_q.push_back(16'hAAA0);
        send_cmd(1'b0, 18'h00010, 1'b1, 4'd3, 16'h0);
        repeat (BEAT + 2) @(negedge clk);
        n_checks++;
        if (oe_n !== 1'b0 || sram_a !== 18'h00011) begin
            n_errors++;
            $display("FAIL rst_mid_setup: OE_N=%b A=%h want 0/00011", oe_n, sram_a);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, busy, wr_ack, rd_valid, err, ce_n, we_n, oe_n} !== 8'b1000_0111) begin
            n_errors++;
            $display("FAIL rst_mid_ctrl: got %b want 10000111",
                     {cmd_ready, busy, wr_ack, rd_valid, err, ce_n, we_n, oe_n});
        end
        n_checks++;
        if ({sram_a, bs_n, rd_data} !== {18'h0, 2'b11, 16'h0} || dut.w_dq_oe !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_data: A=%h BS_N=%b RD=%h dq_oe=%b want 0/11/0/0",
                     sram_a, bs_n, rd_data, dut.w_dq_oe);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_valid) nr++;
        end
        n_checks++;
        if (nr !== 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_after: RD_VALID pulses %0d busy %b want 0/0", nr, busy);
        end
    endtask

    task automatic test_random_mix();
        logic        wr, l;
        logic [17:0] a;
        logic [3:0]  len;
        logic [15:0] d;
        int nb, na, nr, want_busy;
        for (int i = 0; i < 12; i++) begin
            wr  = 1'($urandom_range(0, 1));
            l   = 1'($urandom_range(0, 1));
            a   = 18'(32'h3FFF0 + $urandom_range(0, 31));
            len = 4'($urandom_range(0, 3));
            d   = 16'($urandom);
            if (!wr) begin
                for (int b = 0; b <= int'(len); b++) exp_q.push_back(lane_of(mem_rd(18'(a + 18'(b))), l));
            end
            send_cmd(wr, a, l, len, d);
            wait_idle(nb, na, nr);
            want_busy = (int'(len) + 1) * (wr ? WR_BEAT : BEAT);
            n_checks++;
            if (nb !== want_busy || na !== (wr ? int'(len) + 1 : 0) || nr !== (wr ? 0 : int'(len) + 1)) begin
                n_errors++;
                $display("FAIL rand%0d_counts: busy %0d acks %0d rds %0d want %0d/%0d/%0d", i, nb, na, nr,
                         want_busy, wr ? int'(len) + 1 : 0, wr ? 0 : int'(len) + 1);
            end
            if (wr) begin
                for (int b = 0; b <= int'(len); b++) begin
                    n_checks++;
                    if (lane_of(mem_rd(18'(a + 18'(b))), l) !== d) begin
                        n_errors++;
                        $display("FAIL rand%0d_mem: addr %h got %h want %h", i, 18'(a + 18'(b)),
                                 lane_of(mem_rd(18'(a + 18'(b))), l), d);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_errors++; $display("FAIL rand_missing: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_verify();
        int nb, na, nr;
        stuck_bit0 = 1'b1;
        send_cmd(1'b1, 18'h00050, 1'b0, 4'd0, 16'h0001);
        wait_idle(nb, na, nr);
        stuck_bit0 = 1'b0;
`ifdef SRAM_BURST_CTRL_VERIFY_EN
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL verify_err_set: ERR=%b want 1", err); end
        n_checks++;
        if (nb !== WR_BEAT || nr !== 0) begin
            n_errors++;
            $display("FAIL verify_beat: busy %0d rds %0d want %0d/0", nb, nr, WR_BEAT);
        end
`else
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL err_tied: ERR=%b want 0", err); end
`endif
        exp_q.push_back(16'h0000);
        send_cmd(1'b0, 18'h00050, 1'b0, 4'd0, 16'h0);
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL err_clear: ERR=%b want 0", err); end
        wait_idle(nb, na, nr);
        send_cmd(1'b1, 18'h00051, 1'b1, 4'd0, 16'h0001);
        wait_idle(nb, na, nr);
        n_checks++;
        if (err !== 1'b0 || lane_of(mem_rd(18'h00051), 1'b1) !== 16'h0001) begin
            n_errors++;
            $display("FAIL verify_clean: ERR=%b mem=%h want 0/0001", err, lane_of(mem_rd(18'h00051), 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_back_to_back();
        test_reset_mid_burst();
        test_random_mix();
        test_verify();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
